// File: rtl/disp_ctrl_pkg.sv
// Shared definitions for the DOUT display front end: flash FSM states,
// default timing parameters and display mode constants.
package disp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BLANK     = 2'd0,
    ST_FLASH_OFF = 2'd1,
    ST_FLASH_ON  = 2'd2,
    ST_SHOW      = 2'd3
  } disp_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_FLASH_HALF      = 6250000;
  localparam int DEF_NUM_FLASH       = 3;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  function automatic logic is_flash(input disp_state_e s);
    return (s == ST_FLASH_OFF) || (s == ST_FLASH_ON);
  endfunction

  function automatic logic is_lit(input disp_state_e s);
    return (s == ST_FLASH_ON) || (s == ST_SHOW);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push-button.
// press is a one-cycle pulse in the cycle the debounced level goes to pressed.
module key_debounce
  import disp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic [CW-1:0] cnt_r;
  logic          flip_s;

  assign flip_s = (sync2_r != deb_r) && (cnt_r == CNT_LAST);
  assign press  = flip_s && (sync2_r == 1'b0);

  // synchroniser; idles at released so a held key after reset needs a full debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // stability counter and debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      deb_r <= 1'b1;
    end else if (sync2_r == deb_r) begin
      cnt_r <= '0;
    end else if (flip_s) begin
      cnt_r <= '0;
      deb_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/dout_display_ctrl.sv
// DOUT display front end: capture register, MODE key toggle and the
// blank/flash/steady enable sequencer feeding the 7-segment display stage.
module dout_display_ctrl
  import disp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FLASH_HALF      = DEF_FLASH_HALF,
  parameter int NUM_FLASH       = DEF_NUM_FLASH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dout,
  input  logic       dout_wr,
  input  logic       key_mode_n,
  input  logic       disp_on,
  output logic [7:0] x,
  output logic       mode,
  output logic       enable,
  output logic       fresh
);

  localparam int PW = $clog2(FLASH_HALF) + 1;
  localparam int NW = $clog2(NUM_FLASH) + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_HALF - 1);
  localparam logic [NW-1:0] PAIR_LAST  = NW'(NUM_FLASH - 1);

  disp_state_e   state_r;
  disp_state_e   state_nx_s;
  logic [PW-1:0] phase_r;
  logic [NW-1:0] pair_r;
  logic          phase_done_s;
  logic          pairs_done_s;
  logic          press_s;
  logic          enable_s;
  logic          fresh_s;
  logic [7:0]    x_r;
  logic          mode_r;
  logic          enable_r;
  logic          fresh_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .press (press_s)
  );

  assign phase_done_s = (phase_r == PHASE_LAST);
  assign pairs_done_s = (pair_r == PAIR_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next state; a strobe restarts the flash sequence from any state
  always_comb begin
    state_nx_s = state_r;
    if (dout_wr) begin
      state_nx_s = ST_FLASH_OFF;
    end else begin
      case (state_r)
        ST_BLANK:     state_nx_s = ST_BLANK;
        ST_SHOW:      state_nx_s = ST_SHOW;
        ST_FLASH_OFF: begin
          if (phase_done_s) begin
            state_nx_s = ST_FLASH_ON;
          end else begin
            state_nx_s = ST_FLASH_OFF;
          end
        end
        ST_FLASH_ON: begin
          if (!phase_done_s) begin
            state_nx_s = ST_FLASH_ON;
          end else if (pairs_done_s) begin
            state_nx_s = ST_SHOW;
          end else begin
            state_nx_s = ST_FLASH_OFF;
          end
        end
        default:      state_nx_s = ST_BLANK;
      endcase
    end
  end

  // outputs decoded from the upcoming state so the registered copies line up with it
  always_comb begin
    enable_s = disp_on & is_lit(state_nx_s);
    fresh_s  = is_flash(state_nx_s);
  end

  // phase and pair counters, held at zero outside the flash states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= '0;
      pair_r  <= '0;
    end else if (dout_wr || !is_flash(state_r)) begin
      phase_r <= '0;
      pair_r  <= '0;
    end else if (phase_done_s) begin
      phase_r <= '0;
      if (state_r == ST_FLASH_ON) begin
        pair_r <= pairs_done_s ? '0 : pair_r + NW'(1);
      end else begin
        pair_r <= pair_r;
      end
    end else begin
      phase_r <= phase_r + PW'(1);
    end
  end

  // registered outputs: captured value, mode toggle, enable and fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r      <= 8'h00;
      mode_r   <= MODE_DEC;
      enable_r <= 1'b0;
      fresh_r  <= 1'b0;
    end else begin
      if (dout_wr) begin
        x_r <= dout;
      end else begin
        x_r <= x_r;
      end
      if (press_s) begin
        mode_r <= ~mode_r;
      end else begin
        mode_r <= mode_r;
      end
      enable_r <= enable_s;
      fresh_r  <= fresh_s;
    end
  end

  assign x      = x_r;
  assign mode   = mode_r;
  assign enable = enable_r;
  assign fresh  = fresh_r;

endmodule
